// File: rtl/lector_pulsador_pkg.sv
// Shared types and default timing for the push-button reader.
package lector_pulsador_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  localparam int unsigned LEDS_W              = 5;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 120000;
  localparam int unsigned LONG_CYCLES_DEF     = 12000000;

  function automatic int unsigned max_cycles(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lector_pulsador_sincronizador.sv
// Two-flop synchronizer for asynchronous pins; both flops reset to RST_VAL.
module sincronizador #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lector_pulsador.sv
// Debounces one push-button, counts accepted presses on the LEDs and emits press/release strobes.
// Optional long-press detection with LECTOR_PULSADOR_LONG_PRESS_EN; release strobe is release_pulse (release is a reserved word).
module lector_pulsador
  import lector_pulsador_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn,
  output logic              press,
  output logic              release_pulse,
  output logic              pressed,
  output logic [LEDS_W-1:0] leds,
  output logic              long_press
);

  localparam int unsigned MAX_CYC = max_cycles(DEBOUNCE_CYCLES, LONG_CYCLES);
  localparam int unsigned TIMER_W = $clog2(MAX_CYC + 1);

  localparam logic [TIMER_W-1:0] DEB_LAST  = TIMER_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = '1;

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic               btn_act;
  logic               s;

  assign btn_act = btn ^ ACTIVE_LOW;

  // Inactive level is 0 after polarity correction.
  sincronizador #(
    .RST_VAL (1'b0)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_act),
    .q   (s)
  );

`ifdef LECTOR_PULSADOR_LONG_PRESS_EN
  localparam logic [TIMER_W-1:0] LONG_LAST = TIMER_W'(LONG_CYCLES - 1);

  logic [TIMER_W-1:0] hold;
`else
  assign long_press = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      timer         <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      pressed       <= 1'b0;
      leds          <= '0;
`ifdef LECTOR_PULSADOR_LONG_PRESS_EN
      hold          <= '0;
      long_press    <= 1'b0;
`endif
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;

      case (state)
        IDLE: begin
          if (s) begin
            state <= DEB_PRESS;
            timer <= '0;
          end
        end

        DEB_PRESS: begin
          if (!s) begin
            state <= IDLE;
          end else if (timer == DEB_LAST) begin
            state   <= PRESSED;
            timer   <= '0;
            press   <= 1'b1;
            pressed <= 1'b1;
            leds    <= leds + 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        PRESSED: begin
          if (!s) begin
            state <= DEB_RELEASE;
            timer <= '0;
          end else if (timer != TIMER_MAX) begin
            timer <= timer + 1'b1;
          end
        end

        DEB_RELEASE: begin
          // A bounce back to PRESSED resumes hold timing instead of restarting it.
          if (s) begin
            state <= PRESSED;
`ifdef LECTOR_PULSADOR_LONG_PRESS_EN
            timer <= hold;
`endif
          end else if (timer == DEB_LAST) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            pressed       <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase

`ifdef LECTOR_PULSADOR_LONG_PRESS_EN
      // Saturating hold counter passes LONG_LAST exactly once per hold.
      long_press <= 1'b0;
      if (state == PRESSED || state == DEB_RELEASE) begin
        if (hold != TIMER_MAX) begin
          hold <= hold + 1'b1;
        end
        if (hold == LONG_LAST) begin
          long_press <= 1'b1;
          leds       <= '0;
        end
      end else begin
        hold <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_lector_pulsador.sv
// Directed bench for lector_pulsador with short debounce/long-press timing.
module tb_lector_pulsador;

  logic       clk;
  logic       rst;
  logic       btn;
  logic       press;
  logic       release_pulse;
  logic       pressed;
  logic [4:0] leds;
  logic       long_press;

  int checks = 0;
  int errors = 0;
  int n_press = 0;
  int n_rel = 0;
  int n_long = 0;
  int overlap = 0;

  lector_pulsador #(
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (16),
    .ACTIVE_LOW      (1'b0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn           (btn),
    .press         (press),
    .release_pulse (release_pulse),
    .pressed       (pressed),
    .leds          (leds),
    .long_press    (long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge press) n_press++;
  always @(posedge release_pulse) n_rel++;
  always @(posedge long_press) n_long++;
  always @(negedge clk) if (press && release_pulse) overlap++;

  typedef struct {
    logic       rst;
    logic       btn;
    int         cyc;
    logic [8:0] exp_out;
    int         exp_np;
    int         exp_nr;
  } vec_t;

  vec_t tbl[17];

  function automatic logic [8:0] o(input logic p, input logic r, input logic pd, input logic [4:0] l);
    return {p, r, pd, l, 1'b0};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic press_release();
    btn = 1'b1;
    step(7);
    btn = 1'b0;
    step(8);
  endtask

  logic [8:0] outs;
  int         base;
  logic [4:0] exp_leds;

  initial begin
    rst = 1'b1;
    btn = 1'b0;

    // reset, clean press/release, glitch, bounce on release
    tbl[0]  = '{1'b1, 1'b0, 2, o(0, 0, 0, 5'd0), 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 3, o(0, 0, 0, 5'd0), 0, 0};
    tbl[2]  = '{1'b0, 1'b1, 6, o(0, 0, 0, 5'd0), 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 1, o(1, 0, 1, 5'd1), 1, 0};
    tbl[4]  = '{1'b0, 1'b1, 1, o(0, 0, 1, 5'd1), 1, 0};
    tbl[5]  = '{1'b0, 1'b0, 6, o(0, 0, 1, 5'd1), 1, 0};
    tbl[6]  = '{1'b0, 1'b0, 1, o(0, 1, 0, 5'd1), 1, 1};
    tbl[7]  = '{1'b0, 1'b0, 1, o(0, 0, 0, 5'd1), 1, 1};
    tbl[8]  = '{1'b0, 1'b1, 3, o(0, 0, 0, 5'd1), 1, 1};
    tbl[9]  = '{1'b0, 1'b0, 8, o(0, 0, 0, 5'd1), 1, 1};
    tbl[10] = '{1'b0, 1'b1, 6, o(0, 0, 0, 5'd1), 1, 1};
    tbl[11] = '{1'b0, 1'b1, 1, o(1, 0, 1, 5'd2), 2, 1};
    tbl[12] = '{1'b0, 1'b0, 2, o(0, 0, 1, 5'd2), 2, 1};
    tbl[13] = '{1'b0, 1'b1, 2, o(0, 0, 1, 5'd2), 2, 1};
    tbl[14] = '{1'b0, 1'b0, 6, o(0, 0, 1, 5'd2), 2, 1};
    tbl[15] = '{1'b0, 1'b0, 1, o(0, 1, 0, 5'd2), 2, 2};
    tbl[16] = '{1'b0, 1'b0, 2, o(0, 0, 0, 5'd2), 2, 2};

    for (int i = 0; i < 17; i++) begin
      rst = tbl[i].rst;
      btn = tbl[i].btn;
      step(tbl[i].cyc);
      outs = {press, release_pulse, pressed, leds, long_press};
      check($sformatf("vec%0d_outs", i), 32'(outs), 32'(tbl[i].exp_out));
      check($sformatf("vec%0d_counts", i), 32'(n_press * 256 + n_rel), 32'(tbl[i].exp_np * 256 + tbl[i].exp_nr));
    end

    // wrap: 32 presses from reset
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("wrap_reset_leds", 32'(leds), 32'd0);
    base = n_press;
    for (int i = 0; i < 31; i++) press_release();
    check("wrap_leds_31", 32'(leds), 32'd31);
    press_release();
    check("wrap_leds_0", 32'(leds), 32'd0);
    check("wrap_press_count", 32'(n_press - base), 32'd32);

    // reset mid-debounce with button held
    press_release();
    check("mid_leds_before", 32'(leds), 32'd1);
    btn = 1'b1;
    step(4);
    check("mid_in_debounce", 32'({press, pressed}), 32'd0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mid_after_rst", 32'({press, release_pulse, pressed, leds}), 32'd0);
    base = n_press;
    step(6);
    check("mid_no_early_press", 32'({press, pressed, leds}), 32'd0);
    step(1);
    check("mid_press", 32'({press, pressed, leds}), 32'({1'b1, 1'b1, 5'd1}));
    check("mid_press_once", 32'(n_press - base), 32'd1);

    // long press
    btn = 1'b0;
    step(8);
    press_release();
    btn = 1'b1;
    step(7);
    check("long_entry", 32'({press, leds}), 32'({1'b1, 5'd3}));
    base = n_long;
    step(15);
    check("long_not_yet", 32'({long_press, leds}), 32'({1'b0, 5'd3}));
    step(1);
`ifdef LECTOR_PULSADOR_LONG_PRESS_EN
    exp_leds = 5'd0;
    check("long_fire", 32'({long_press, leds}), 32'({1'b1, 5'd0}));
`else
    exp_leds = 5'd3;
    check("long_fire", 32'({long_press, leds}), 32'({1'b0, 5'd3}));
`endif
    step(4);
    check("long_one_cycle", 32'({long_press, leds}), 32'({1'b0, exp_leds}));
    step(10);
`ifdef LECTOR_PULSADOR_LONG_PRESS_EN
    check("long_count", 32'(n_long - base), 32'd1);
`else
    check("long_count", 32'(n_long - base), 32'd0);
`endif
    btn = 1'b0;
    step(7);
    check("long_release", 32'({release_pulse, pressed, leds}), 32'({1'b1, 1'b0, exp_leds}));
    step(1);
    check("long_release_end", 32'({release_pulse, long_press}), 32'd0);

    check("no_overlap", 32'(overlap), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
